// File: rtl/fifo_seq_checker.sv
// fifo_seq_checker: drives a FIFO write port with a known word sequence and checks the read side against it.
// Optional macro SEQ_LFSR_EN adds a Galois LFSR sequence (picked by mode at reset); default build is increment only.
module fifo_seq_checker #(
   parameter int           W            = 12,
   parameter int           CNT_W        = 32,
   parameter int           ERR_W        = 16,
   parameter logic [W-1:0] SEED         = '0,
   parameter int           STOP_ON_FAIL = 1,
   parameter logic [W-1:0] POLY         = W'('hE08)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   output logic             w,
   output logic [W-1:0]     wd,
   input  logic             wok,
   output logic             r,
   input  logic [W-1:0]     rd,
   input  logic             rok,
   output logic             fail,
   output logic [ERR_W-1:0] errcnt,
   output logic [CNT_W-1:0] wcount,
   output logic [CNT_W-1:0] rcount,
   output logic [W-1:0]     errexp,
   output logic [W-1:0]     errgot
);

   localparam logic STOP = (STOP_ON_FAIL != 0);

   logic [W-1:0] expected;
   logic         wxfer;
   logic         rxfer;
   logic         mismatch;

`ifdef SEQ_LFSR_EN
   logic lfsr_sel;

   always_ff @(posedge clk) begin
      if (rst)
         lfsr_sel <= mode;
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{mode, POLY};
`endif

   function automatic logic [W-1:0] seq_next(input logic [W-1:0] x);
`ifdef SEQ_LFSR_EN
      if (lfsr_sel)
         return (x >> 1) ^ (x[0] ? POLY : '0);
`endif
      return x + W'(1);
   endfunction

   assign wxfer    = w && wok;
   assign rxfer    = r && rok;
   assign mismatch = rxfer && (rd != expected);

   // Generator: wd only advances on an accepted write, so a stalled FIFO never skips a value.
   always_ff @(posedge clk) begin
      if (rst) begin
         w      <= 1'b0;
         wd     <= SEED;
         wcount <= '0;
      end else begin
         w <= en;
         if (wxfer) begin
            wd <= seq_next(wd);
            if (wcount != '1)
               wcount <= wcount + CNT_W'(1);
         end
      end
   end

   // Checker: on a mismatch, resync to the received word so one lost word costs one error.
   always_ff @(posedge clk) begin
      if (rst) begin
         r        <= 1'b0;
         expected <= SEED;
         fail     <= 1'b0;
         errcnt   <= '0;
         rcount   <= '0;
         errexp   <= '0;
         errgot   <= '0;
      end else begin
         r <= en && !(STOP && (fail || mismatch));
         if (rxfer) begin
            if (rcount != '1)
               rcount <= rcount + CNT_W'(1);
            if (mismatch) begin
               fail <= 1'b1;
               if (errcnt != '1)
                  errcnt <= errcnt + ERR_W'(1);
               if (errcnt == '0) begin
                  errexp <= expected;
                  errgot <= rd;
               end
               expected <= seq_next(rd);
            end else begin
               expected <= seq_next(expected);
            end
         end
      end
   end

endmodule
